// File: rtl/button_conditioner.sv
// Push-button/switch conditioner: 2-FF synchronizer, per-channel debounce and press one-shot.
// Define BTN_AUTOREPEAT_EN to compile in the hold-to-repeat logic gated by RPT_MASK.
module button_conditioner #(
    parameter int               N_BTN             = 7,
    parameter int               DB_CYCLES         = 1000000,
    parameter int               RPT_DELAY_CYCLES  = 50000000,
    parameter int               RPT_PERIOD_CYCLES = 10000000,
    parameter logic [N_BTN-1:0] RPT_MASK          = N_BTN'(7'b0111111)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam int DB_W = $clog2(DB_CYCLES);

    if (DB_CYCLES < 2 || RPT_DELAY_CYCLES < 1 || RPT_PERIOD_CYCLES < 1 ||
        $bits(RPT_MASK) != N_BTN) begin : g_param_check
        $error("button_conditioner: invalid parameter set");
    end

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] pulse_q, pulse_d;
    logic [N_BTN-1:0] rise;
    logic [DB_W-1:0]  db_cnt_q [N_BTN];
    logic [DB_W-1:0]  db_cnt_d [N_BTN];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // A toggle needs DB_CYCLES consecutive disagreeing samples; any agreement restarts the count.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            // NOTE: every combinational output gets a default first so no latch is inferred.
            stable_d[i] = stable_q[i];
            db_cnt_d[i] = '0;
            rise[i]     = 1'b0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                    rise[i]     = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // NOTE: the counter arrays are small per-channel registers, so they are reset like any flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q <= '0;
            pulse_q  <= '0;
            for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= '0;
        end else begin
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT,
        ST_HOLD
    } rpt_state_e;

    localparam int RPT_MAX = (RPT_DELAY_CYCLES > RPT_PERIOD_CYCLES) ?
                             RPT_DELAY_CYCLES : RPT_PERIOD_CYCLES;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    rpt_state_e       state_q   [N_BTN];
    rpt_state_e       state_d   [N_BTN];
    logic [RPT_W-1:0] rpt_cnt_q [N_BTN];
    logic [RPT_W-1:0] rpt_cnt_d [N_BTN];

    // Decisions use the next stable level so a release suppresses a coincident repeat pulse.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i]   = state_q[i];
            rpt_cnt_d[i] = rpt_cnt_q[i];
            pulse_d[i]   = 1'b0;
            if (!stable_d[i]) begin
                state_d[i]   = ST_IDLE;
                rpt_cnt_d[i] = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (rise[i]) begin
                            pulse_d[i]   = 1'b1;
                            rpt_cnt_d[i] = '0;
                            state_d[i]   = RPT_MASK[i] ? ST_DELAY : ST_HOLD;
                        end
                    end
                    ST_DELAY: begin
                        if (rpt_cnt_q[i] == RPT_W'(RPT_DELAY_CYCLES - 1)) begin
                            pulse_d[i]   = 1'b1;
                            rpt_cnt_d[i] = '0;
                            state_d[i]   = ST_REPEAT;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (rpt_cnt_q[i] == RPT_W'(RPT_PERIOD_CYCLES - 1)) begin
                            pulse_d[i]   = 1'b1;
                            rpt_cnt_d[i] = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        rpt_cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i]   <= ST_IDLE;
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i]   <= state_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
        end
    end
`else
    assign pulse_d = rise;
`endif

    assign btn_level = stable_q;
    assign btn_pulse = pulse_q;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw push-button and switch inputs before they reach the clock/calendar top level.
- Each channel passes through a 2-FF synchronizer, a per-channel debounce counter and a rising-edge one-shot.
- Channels enabled in RPT_MASK can also auto-repeat while held.
- The outputs drive add_hour, add_min, add_cen, add_year, add_month, add_day (pulses) and am_or_pm (level) of the clock/calendar top.

Parameters:
- N_BTN, 7, number of independent input channels.
- DB_CYCLES, 1000000, clk cycles the synchronized input must hold a new value before the debounced level changes; must be ≥2.
- RPT_DELAY_CYCLES, 50000000, clk cycles from the press pulse to the first auto-repeat pulse.
- RPT_PERIOD_CYCLES, 10000000, clk cycles between later auto-repeat pulses.
- RPT_MASK, 7'b0111111, per-channel auto-repeat enable; bit i=1 allows channel i to repeat.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- btn_raw  input  N_BTN  raw asynchronous button/switch inputs, active-high.
- btn_level  output  N_BTN  debounced level per channel.
- btn_pulse  output  N_BTN  single-cycle press pulse per channel, plus auto-repeat pulses.

Behaviour:
- Reset (reset=0, asynchronous): all synchronizer flops, stable levels, debounce counters, repeat counters and btn_pulse clear to 0. btn_level=0, btn_pulse=0 while reset is held and on the first edge after release.
- Synchronizer: two flops per channel. sync = second stage.
- Debounce, per channel, counter width $clog2(DB_CYCLES):
  - sync == stable: counter is cleared to 0.
  - sync != stable: counter increments.
  - On the edge where counter == DB_CYCLES-1 and sync != stable: stable toggles and counter clears.
  - Any reversion of sync before that edge clears the counter, so no toggle occurs.
- Latency: btn_level changes exactly DB_CYCLES+2 rising edges after btn_raw settles at a new value. btn_level = stable, registered.
- Press pulse: btn_pulse[i]=1 for exactly one cycle, the same cycle btn_level[i] first reads 1.
- Release: btn_level falls after the same latency. No pulse is generated on release.
- Per-channel state machine (inside the auto-repeat logic):
  - IDLE: stable=0. On the stable 0→1 edge, issue the press pulse, load rpt_cnt=0, go to DELAY.
  - DELAY: rpt_cnt increments each cycle. When rpt_cnt == RPT_DELAY_CYCLES-1, pulse, clear rpt_cnt, go to REPEAT.
  - REPEAT: rpt_cnt increments. When rpt_cnt == RPT_PERIOD_CYCLES-1, pulse and clear rpt_cnt.
  - Any state: stable=0 goes to IDLE immediately, with no pulse that cycle.
  - Channels with RPT_MASK[i]=0 remain in IDLE after the press pulse until release (a HOLD state is acceptable), and never repeat.
- Repeat pulse spacing:
  - First repeat pulse: RPT_DELAY_CYCLES cycles after the press pulse.
  - Later repeat pulses: every RPT_PERIOD_CYCLES cycles.
- Simultaneous events: channels are fully independent. Any number of btn_pulse bits may be high in one cycle.
- Reset mid-hold: everything clears. If btn_raw is still 1 after reset release, a fresh press pulse occurs DB_CYCLES+2 edges later.
- Counter saturation: the debounce counter never exceeds DB_CYCLES-1. rpt_cnt never exceeds max(RPT_DELAY_CYCLES, RPT_PERIOD_CYCLES)-1.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: DELAY/REPEAT states and rpt_cnt logic are compiled in, behaving as above, gated by RPT_MASK.
- Undefined: repeat logic and rpt_cnt are absent. RPT_MASK is ignored. btn_pulse carries only the single press pulse per debounced 0→1 transition. All other behaviour is identical.

Test Plan (DB_CYCLES=4, RPT_DELAY_CYCLES=20, RPT_PERIOD_CYCLES=8, N_BTN=7, macro defined unless stated):
- Clean press: btn_raw[0] 0→1 and held 100 cycles -> btn_level[0]=1 and btn_pulse[0]=1 together exactly 6 edges later, for one cycle.
- Bounce rejection: btn_raw[1] toggles every 2 cycles for 20 cycles, then 0 -> btn_level[1] stays 0, btn_pulse[1] never asserts.
- Auto-repeat: hold btn_raw[2] for 60 cycles after the press pulse at cycle P -> pulses at P, P+20, P+28, P+36, P+44, P+52. None after release. btn_level falls 6 edges after btn_raw falls.
- Masked channel: hold btn_raw[6] (RPT_MASK[6]=0) for 60 cycles -> exactly one pulse; btn_level[6] stays 1 throughout.
- Reset mid-hold: assert reset at P+25 while channel 2 is held, release 3 cycles later with btn_raw[2] still 1 -> all outputs 0 during reset. A new press pulse occurs 6 edges after release, then repeat timing restarts.
- Macro undefined: repeat the auto-repeat scenario -> only the pulse at P. Simultaneous press of channels 0 and 3 in the same cycle -> both pulses in the same cycle.
